ps2_keyboard: RTL

//   Receives PS/2 set-2 scancodes from the keyboard pins and translates them into Hack key codes.

---
 rtl/ps2_kb_pkg.sv | 83 ++++++++
 rtl/ps2_keyboard_if.sv | 12 +
 rtl/ps2_rx_frame.sv | 106 ++++++++++
 rtl/ps2_keyboard.sv | 117 +++++++++++
 4 files changed

// File: rtl/ps2_kb_pkg.sv
// Shared types, scancode constants and the set-2 to Hack key-code translation.
// Optional macro KB_SHIFT_EN selects shift-aware (lowercase/shifted) translation.
package ps2_kb_pkg;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} rx_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    localparam logic [7:0] HACK_ENTER = 8'd128;
    localparam logic [7:0] HACK_BKSP  = 8'd129;
    localparam logic [7:0] HACK_LEFT  = 8'd130;
    localparam logic [7:0] HACK_UP    = 8'd131;
    localparam logic [7:0] HACK_RIGHT = 8'd132;
    localparam logic [7:0] HACK_DOWN  = 8'd133;
    localparam logic [7:0] HACK_HOME  = 8'd134;
    localparam logic [7:0] HACK_END   = 8'd135;
    localparam logic [7:0] HACK_PGUP  = 8'd136;
    localparam logic [7:0] HACK_PGDN  = 8'd137;
    localparam logic [7:0] HACK_INS   = 8'd138;
    localparam logic [7:0] HACK_DEL   = 8'd139;
    localparam logic [7:0] HACK_ESC   = 8'd140;
    localparam logic [7:0] HACK_F1    = 8'd141;

    // Returns 0 for unmapped keys; each table entry is {unshifted, shifted}.
    function automatic logic [15:0] ps2_to_hack(input logic ext, input logic [7:0] code,
                                                input logic shift);
        logic [15:0] pair;
        logic [7:0]  ch;
        pair = 16'h0000;
        if (ext) begin
            case (code)
                8'h6B: pair = {2{HACK_LEFT}};  8'h75: pair = {2{HACK_UP}};
                8'h74: pair = {2{HACK_RIGHT}}; 8'h72: pair = {2{HACK_DOWN}};
                8'h6C: pair = {2{HACK_HOME}};  8'h69: pair = {2{HACK_END}};
                8'h7D: pair = {2{HACK_PGUP}};  8'h7A: pair = {2{HACK_PGDN}};
                8'h70: pair = {2{HACK_INS}};   8'h71: pair = {2{HACK_DEL}};
                8'h5A: pair = {2{HACK_ENTER}}; 8'h4A: pair = "//";
                default: pair = 16'h0000;
            endcase
        end else begin
            case (code)
                8'h1C: pair = "aA"; 8'h32: pair = "bB"; 8'h21: pair = "cC"; 8'h23: pair = "dD";
                8'h24: pair = "eE"; 8'h2B: pair = "fF"; 8'h34: pair = "gG"; 8'h33: pair = "hH";
                8'h43: pair = "iI"; 8'h3B: pair = "jJ"; 8'h42: pair = "kK"; 8'h4B: pair = "lL";
                8'h3A: pair = "mM"; 8'h31: pair = "nN"; 8'h44: pair = "oO"; 8'h4D: pair = "pP";
                8'h15: pair = "qQ"; 8'h2D: pair = "rR"; 8'h1B: pair = "sS"; 8'h2C: pair = "tT";
                8'h3C: pair = "uU"; 8'h2A: pair = "vV"; 8'h1D: pair = "wW"; 8'h22: pair = "xX";
                8'h35: pair = "yY"; 8'h1A: pair = "zZ";
                8'h45: pair = "0)"; 8'h16: pair = "1!"; 8'h1E: pair = "2@"; 8'h26: pair = "3#";
                8'h25: pair = "4$"; 8'h2E: pair = "5%"; 8'h36: pair = "6^"; 8'h3D: pair = "7&";
                8'h3E: pair = "8*"; 8'h46: pair = "9(";
                8'h0E: pair = "`~"; 8'h4E: pair = "-_"; 8'h55: pair = "=+"; 8'h5D: pair = "\\|";
                8'h54: pair = "[{"; 8'h5B: pair = "]}"; 8'h4C: pair = ";:"; 8'h52: pair = "'\"";
                8'h41: pair = ",<"; 8'h49: pair = ".>"; 8'h4A: pair = "/?"; 8'h29: pair = "  ";
                8'h70: pair = "00"; 8'h69: pair = "11"; 8'h72: pair = "22"; 8'h7A: pair = "33";
                8'h6B: pair = "44"; 8'h73: pair = "55"; 8'h74: pair = "66"; 8'h6C: pair = "77";
                8'h75: pair = "88"; 8'h7D: pair = "99"; 8'h71: pair = ".."; 8'h7C: pair = "**";
                8'h7B: pair = "--"; 8'h79: pair = "++";
                8'h5A: pair = {2{HACK_ENTER}}; 8'h66: pair = {2{HACK_BKSP}};
                8'h76: pair = {2{HACK_ESC}};
                8'h05: pair = {2{HACK_F1}};          8'h06: pair = {2{HACK_F1 + 8'd1}};
                8'h04: pair = {2{HACK_F1 + 8'd2}};   8'h0C: pair = {2{HACK_F1 + 8'd3}};
                8'h03: pair = {2{HACK_F1 + 8'd4}};   8'h0B: pair = {2{HACK_F1 + 8'd5}};
                8'h83: pair = {2{HACK_F1 + 8'd6}};   8'h0A: pair = {2{HACK_F1 + 8'd7}};
                8'h01: pair = {2{HACK_F1 + 8'd8}};   8'h09: pair = {2{HACK_F1 + 8'd9}};
                8'h78: pair = {2{HACK_F1 + 8'd10}};  8'h07: pair = {2{HACK_F1 + 8'd11}};
                default: pair = 16'h0000;
            endcase
        end
        ch = shift ? pair[7:0] : pair[15:8];
`ifdef KB_SHIFT_EN
        return {8'h00, ch};
`else
        // Without shift tracking letters are always reported in uppercase.
        return (ch >= "a" && ch <= "z") ? {8'h00, ch - 8'd32} : {8'h00, ch};
`endif
    endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// PS/2 pins plus the decoded keyboard outputs seen by DataMemory.
interface ps2_keyboard_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] kb_out;
    logic        scan_valid;
    logic        frame_err;
    logic [7:0]  last_scan;

    modport master (output ps2_clk, ps2_data, input kb_out, scan_valid, frame_err, last_scan);
    modport slave  (input ps2_clk, ps2_data, output kb_out, scan_valid, frame_err, last_scan);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 pin synchronisers, 11-bit frame receiver and mid-frame timeout.
module ps2_rx_frame
    import ps2_kb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    rx_state_e              state_q, state_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   bit_q, bit_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic                   valid_q, valid_d, err_q, err_d;
    logic                   ps2_clk_s, ps2_data_s, fall;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~ps2_clk_s;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tmo_d   = fall ? '0 : tmo_q + TmoW'(1);
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: if (fall) begin
                bit_d   = ps2_data_s;
                state_d = StStart;
            end
            StStart: begin
                cnt_d = '0;
                if (bit_q) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StData;
                end
            end
            StData: if (fall) begin
                shreg_d = {ps2_data_s, shreg_q[7:1]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = StParity;
            end
            StParity: if (fall) begin
                bit_d   = ps2_data_s;
                state_d = StStop;
            end
            StStop: if (fall) begin
                state_d = StIdle;
                if (ps2_data_s && (^{shreg_q, bit_q})) valid_d = 1'b1;
                else                                   err_d   = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && !fall && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end
        if (state_d == StIdle) tmo_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            bit_q       <= 1'b0;
            tmo_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= ps2_clk_s;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tmo_q       <= tmo_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign rx_byte_o    = shreg_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = err_q;
endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard to Hack kb_in word: prefix/shift tracking and held-key register.
// Define KB_SHIFT_EN to track the shift keys and emit lowercase/shifted ASCII.
module ps2_keyboard
    import ps2_kb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input logic           clk,
    input logic           reset,
    ps2_keyboard_if.slave kb
);
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_err, shift;
    logic [15:0] hack;
    logic        ext_q, ext_d, brk_q, brk_d;
    logic [15:0] kb_out_q, kb_out_d;
    logic [8:0]  last_key_q, last_key_d;
    logic [7:0]  last_scan_q, last_scan_d;
    logic        scan_valid_q, frame_err_q;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (kb.ps2_clk),
        .ps2_data_i  (kb.ps2_data),
        .rx_byte_o   (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_err)
    );

`ifdef KB_SHIFT_EN
    logic lshift_q, lshift_d, rshift_q, rshift_d;
    assign shift = lshift_q | rshift_q;
`else
    assign shift = 1'b0;
`endif

    assign hack = ps2_to_hack(ext_q, rx_byte, shift);

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        kb_out_d    = kb_out_q;
        last_key_d  = last_key_q;
        last_scan_d = last_scan_q;
`ifdef KB_SHIFT_EN
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
`endif
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        if (rx_valid) begin
            last_scan_d = rx_byte;
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else if (rx_byte != PS2_PAUSE) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
`ifdef KB_SHIFT_EN
                if (!ext_q && rx_byte == PS2_LSHIFT)      lshift_d = !brk_q;
                else if (!ext_q && rx_byte == PS2_RSHIFT) rshift_d = !brk_q;
                else
`endif
                if (hack != 16'd0) begin
                    if (!brk_q) begin
                        kb_out_d   = hack;
                        last_key_d = {ext_q, rx_byte};
                    // Same physical key releases even if shift changed its translation.
                    end else if (hack == kb_out_q || {ext_q, rx_byte} == last_key_q) begin
                        kb_out_d = 16'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            kb_out_q     <= '0;
            last_key_q   <= '0;
            last_scan_q  <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef KB_SHIFT_EN
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
`endif
        end else begin
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            kb_out_q     <= kb_out_d;
            last_key_q   <= last_key_d;
            last_scan_q  <= last_scan_d;
            scan_valid_q <= rx_valid;
            frame_err_q  <= rx_err;
`ifdef KB_SHIFT_EN
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
`endif
        end
    end

    assign kb.kb_out     = kb_out_q;
    assign kb.scan_valid = scan_valid_q;
    assign kb.frame_err  = frame_err_q;
    assign kb.last_scan  = last_scan_q;
endmodule
